// File: rtl/branch_resolve_queue.sv
// In-order branch resolution queue for the gshare predictor: holds {pc, ghr, taken}
// per in-flight branch, then emits the counter update, the flush/GHR recovery and the accuracy counters.
module branch_resolve_queue #(
  parameter int DEPTH = 8,
  parameter int PC_W  = 8,
  parameter int GHR_W = 8,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     pred_valid,
  input  logic [PC_W-1:0]          pred_pc,
  input  logic [GHR_W-1:0]         pred_ghr,
  input  logic                     pred_taken,
  output logic                     pred_ready,
  input  logic                     res_valid,
  input  logic                     res_taken,
  output logic                     res_ready,
  output logic                     upd_valid,
  output logic [PC_W-1:0]          upd_index,
  output logic                     upd_taken,
  output logic                     mispredict,
  output logic [GHR_W-1:0]         recover_ghr,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic [CNT_W-1:0]         total_branches,
  output logic [CNT_W-1:0]         correct_predictions
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]    FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]    CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0]  PTR_ONE  = AW'(1);
  localparam logic [CNT_W-1:0] ACC_ONE = CNT_W'(1);

  typedef struct packed {
    logic [PC_W-1:0]  pc;
    logic [GHR_W-1:0] ghr;
    logic             taken;
  } entry_t;

  entry_t          mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     count;
  logic            upd_valid_q;

  entry_t head;
  logic   pop;
  logic   push;
  logic   head_mis;

  assign pred_ready = (count != FULL_CNT);
  assign res_ready  = (count != '0);
  assign occupancy  = count;

  assign head     = mem[rd_ptr];
  assign pop      = res_valid && res_ready;
  assign head_mis = (head.taken != res_taken);
  // A push alongside a mispredicting pop is on the wrong path and is dropped.
  assign push     = pred_valid && pred_ready && !(pop && head_mis);

  // A reset arriving while a pulse is on the port cancels it before the consumer acts on it.
  assign upd_valid = upd_valid_q && !reset;

  // NOTE: the entry array carries no reset; validity is tracked by count/pointers alone,
  // which keeps the storage a plain register file without a reset network.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{pc: pred_pc, ghr: pred_ghr, taken: pred_taken};
  end

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr              <= '0;
      rd_ptr              <= '0;
      count               <= '0;
      upd_valid_q         <= 1'b0;
      upd_index           <= '0;
      upd_taken           <= 1'b0;
      mispredict          <= 1'b0;
      recover_ghr         <= '0;
      total_branches      <= '0;
      correct_predictions <= '0;
    end else begin
      upd_valid_q <= pop;
      if (pop) begin
        upd_index   <= head.pc ^ head.ghr;
        upd_taken   <= res_taken;
        mispredict  <= head_mis;
        recover_ghr <= {head.ghr[GHR_W-2:0], res_taken};
        if (total_branches != '1) total_branches <= total_branches + ACC_ONE;
        if (!head_mis && correct_predictions != '1)
          correct_predictions <= correct_predictions + ACC_ONE;
      end

      if (pop && head_mis) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_ONE;
        if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
        if (push && !pop)      count <= count + CNT_ONE;
        else if (pop && !push) count <= count - CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Self-checking bench for branch_resolve_queue: a FIFO model feeds a scoreboard of expected
// update pulses that is compared one cycle after each resolution.
module tb_branch_resolve_queue;

  localparam int DEPTH = 8;
  localparam int CMAX  = 65535;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1;
  logic       pred_valid = 1'b0, pred_taken = 1'b0, res_valid = 1'b0, res_taken = 1'b0;
  logic [7:0] pred_pc = '0, pred_ghr = '0;
  logic       pred_ready, res_ready, upd_valid, upd_taken, mispredict;
  logic [7:0] upd_index, recover_ghr;
  logic [3:0] occupancy;
  logic [15:0] total_branches, correct_predictions;

  branch_resolve_queue #(.DEPTH(DEPTH), .PC_W(8), .GHR_W(8), .CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .pred_valid(pred_valid), .pred_pc(pred_pc), .pred_ghr(pred_ghr), .pred_taken(pred_taken),
    .pred_ready(pred_ready),
    .res_valid(res_valid), .res_taken(res_taken), .res_ready(res_ready),
    .upd_valid(upd_valid), .upd_index(upd_index), .upd_taken(upd_taken),
    .mispredict(mispredict), .recover_ghr(recover_ghr), .occupancy(occupancy),
    .total_branches(total_branches), .correct_predictions(correct_predictions)
  );

  // Narrow-counter instance so counter saturation is reachable in a few cycles.
  logic       s_pred_valid = 1'b0, s_res_valid = 1'b0, s_res_taken = 1'b0;
  logic       s_pred_ready, s_res_ready, s_upd_valid, s_upd_taken, s_mispredict;
  logic [7:0] s_upd_index, s_recover_ghr;
  logic [3:0] s_occupancy;
  logic [2:0] s_total, s_correct;

  branch_resolve_queue #(.DEPTH(DEPTH), .PC_W(8), .GHR_W(8), .CNT_W(3)) dut_sat (
    .clk(clk), .reset(reset),
    .pred_valid(s_pred_valid), .pred_pc(8'h20), .pred_ghr(8'h00), .pred_taken(1'b1),
    .pred_ready(s_pred_ready),
    .res_valid(s_res_valid), .res_taken(s_res_taken), .res_ready(s_res_ready),
    .upd_valid(s_upd_valid), .upd_index(s_upd_index), .upd_taken(s_upd_taken),
    .mispredict(s_mispredict), .recover_ghr(s_recover_ghr), .occupancy(s_occupancy),
    .total_branches(s_total), .correct_predictions(s_correct)
  );

  typedef struct { logic [7:0] pc; logic [7:0] ghr; logic taken; } ent_t;
  typedef struct { logic [7:0] idx; logic tk; logic mis; logic [7:0] rec; } upd_t;

  ent_t model[$];
  upd_t sb[$];
  int   m_tot = 0, m_cor = 0;
  int   n_tests = 0, n_fail = 0;

  // One clock edge: predicts the DUT's behaviour from the model, then compares after the edge.
  task automatic step();
    bit   do_pop, do_push, mis;
    ent_t h;
    upd_t u;
    do_pop  = !reset && res_valid && model.size() > 0;
    do_push = !reset && pred_valid && model.size() < DEPTH;
    @(posedge clk);
    #1;
    if (reset) begin
      model.delete(); sb.delete(); m_tot = 0; m_cor = 0;
    end else begin
      if (do_pop) begin
        h = model.pop_front();
        mis = (h.taken != res_taken);
        u.idx = h.pc ^ h.ghr; u.tk = res_taken; u.mis = mis; u.rec = {h.ghr[6:0], res_taken};
        sb.push_back(u);
        if (m_tot < CMAX) m_tot++;
        if (!mis && m_cor < CMAX) m_cor++;
        if (mis) begin model.delete(); do_push = 0; end
      end
      if (do_push) begin
        h.pc = pred_pc; h.ghr = pred_ghr; h.taken = pred_taken;
        model.push_back(h);
      end
    end

    n_tests++;
    if (occupancy !== 4'(model.size())) begin
      n_fail++; $display("FAIL occupancy: got %0d expected %0d", occupancy, model.size());
    end
    n_tests++;
    if (pred_ready !== (model.size() < DEPTH) || res_ready !== (model.size() > 0)) begin
      n_fail++; $display("FAIL ready: got pred_ready=%b res_ready=%b for size %0d",
                         pred_ready, res_ready, model.size());
    end
    n_tests++;
    if (total_branches !== 16'(m_tot) || correct_predictions !== 16'(m_cor)) begin
      n_fail++; $display("FAIL counters: got %0d/%0d expected %0d/%0d",
                         total_branches, correct_predictions, m_tot, m_cor);
    end
    n_tests++;
    if (sb.size() > 0) begin
      u = sb.pop_front();
      if (upd_valid !== 1'b1 || upd_index !== u.idx || upd_taken !== u.tk || mispredict !== u.mis ||
          (u.mis && recover_ghr !== u.rec)) begin
        n_fail++;
        $display("FAIL update: got v=%b idx=%h tk=%b mis=%b rec=%h expected v=1 idx=%h tk=%b mis=%b rec=%h",
                 upd_valid, upd_index, upd_taken, mispredict, recover_ghr, u.idx, u.tk, u.mis, u.rec);
      end
    end else if (upd_valid !== 1'b0) begin
      n_fail++; $display("FAIL update_idle: got upd_valid=%b expected 0", upd_valid);
    end
  endtask

  task automatic drive(input bit pv, input logic [7:0] pc, input logic [7:0] ghr, input bit pt,
                       input bit rv, input bit rt);
    pred_valid = pv; pred_pc = pc; pred_ghr = ghr; pred_taken = pt;
    res_valid = rv; res_taken = rt;
    step();
    pred_valid = 1'b0; res_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++;
    if (pred_ready !== 1'b1 || res_ready !== 1'b0 || occupancy !== 4'd0 || upd_valid !== 1'b0 ||
        upd_index !== 8'h00 || upd_taken !== 1'b0 || mispredict !== 1'b0 || recover_ghr !== 8'h00 ||
        total_branches !== 16'd0 || correct_predictions !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_values: got pr=%b rr=%b occ=%0d uv=%b idx=%h ut=%b mis=%b rec=%h tot=%0d cor=%0d expected 1 0 0 0 00 0 0 00 0 0",
               pred_ready, res_ready, occupancy, upd_valid, upd_index, upd_taken, mispredict,
               recover_ghr, total_branches, correct_predictions);
    end
  endtask

  task automatic test_correct();
    drive(1, 8'h10, 8'h00, 1, 0, 0);
    drive(0, 8'h00, 8'h00, 0, 1, 1);
    n_tests++;
    if (upd_index !== 8'h10 || mispredict !== 1'b0 || total_branches !== 16'd1 ||
        correct_predictions !== 16'd1 || res_ready !== 1'b0) begin
      n_fail++; $display("FAIL correct_pop: got idx=%h mis=%b tot=%0d cor=%0d rr=%b expected 10 0 1 1 0",
                         upd_index, mispredict, total_branches, correct_predictions, res_ready);
    end
  endtask

  task automatic test_mispredict();
    do_reset();
    drive(1, 8'h40, 8'h0F, 1, 0, 0);
    drive(1, 8'h41, 8'h1F, 1, 0, 0);
    drive(0, 8'h00, 8'h00, 0, 1, 0);
    n_tests++;
    if (upd_index !== 8'h4F || mispredict !== 1'b1 || recover_ghr !== 8'h1E || occupancy !== 4'd0 ||
        total_branches !== 16'd1 || correct_predictions !== 16'd0) begin
      n_fail++; $display("FAIL mispredict: got idx=%h mis=%b rec=%h occ=%0d tot=%0d cor=%0d expected 4f 1 1e 0 1 0",
                         upd_index, mispredict, recover_ghr, occupancy, total_branches, correct_predictions);
    end
  endtask

  task automatic test_full_and_back_to_back();
    for (int i = 0; i < DEPTH; i++) drive(1, 8'(8'h80 + i), 8'(i * 3), i[0], 0, 0);
    n_tests++;
    if (pred_ready !== 1'b0) begin
      n_fail++; $display("FAIL full_ready: got pred_ready=%b expected 0", pred_ready);
    end
    drive(1, 8'hEE, 8'hEE, 1, 0, 0);
    for (int i = 0; i < 10; i++) begin
      // A push offered while full is refused even with a same-cycle pop, so the occupancy dips to 7.
      drive(model.size() < DEPTH, 8'(8'hA0 + i), 8'(i), i[1], 1, model[0].taken);
    end
    n_tests++;
    if (occupancy !== 4'd7) begin
      n_fail++; $display("FAIL back_to_back_occ: got %0d expected 7", occupancy);
    end
    while (model.size() > 0) drive(0, 8'h00, 8'h00, 0, 1, model[0].taken);
  endtask

  task automatic test_flush_drops_push();
    drive(1, 8'h50, 8'h05, 0, 0, 0);
    drive(1, 8'h55, 8'h01, 1, 1, 1);
    n_tests++;
    if (occupancy !== 4'd0 || mispredict !== 1'b1) begin
      n_fail++; $display("FAIL flush_drop: got occ=%0d mis=%b expected 0 1", occupancy, mispredict);
    end
  endtask

  task automatic test_empty_and_reset_mid();
    logic [15:0] tot_before;
    tot_before = total_branches;
    drive(0, 8'h00, 8'h00, 0, 1, 1);
    n_tests++;
    if (upd_valid !== 1'b0 || total_branches !== tot_before) begin
      n_fail++; $display("FAIL empty_resolve: got uv=%b tot=%0d expected 0 %0d",
                         upd_valid, total_branches, tot_before);
    end
    drive(1, 8'h33, 8'h11, 1, 0, 0);
    drive(1, 8'h34, 8'h12, 0, 1, 1);
    reset = 1'b1;
    #1;
    n_tests++;
    if (upd_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_suppress: got upd_valid=%b expected 0", upd_valid);
    end
    step();
    reset = 1'b0;
    n_tests++;
    if (occupancy !== 4'd0 || upd_index !== 8'h00 || recover_ghr !== 8'h00 || total_branches !== 16'd0) begin
      n_fail++; $display("FAIL reset_mid: got occ=%0d idx=%h rec=%h tot=%0d expected 0 00 00 0",
                         occupancy, upd_index, recover_ghr, total_branches);
    end
  endtask

  task automatic test_random();
    bit rt;
    for (int i = 0; i < 200; i++) begin
      rt = (model.size() > 0 && $urandom_range(0, 7) != 0) ? model[0].taken : 1'($urandom_range(0, 1));
      drive($urandom_range(0, 2) != 0, 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)),
            $urandom_range(0, 2) == 0, rt);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      s_pred_valid = 1'b1; s_res_valid = 1'b1; s_res_taken = 1'b1;
      @(posedge clk); #1;
    end
    s_pred_valid = 1'b0; s_res_taken = 1'b0;
    n_tests++;
    if (s_total !== 3'd7 || s_correct !== 3'd7) begin
      n_fail++; $display("FAIL sat_correct: got %0d/%0d expected 7/7", s_total, s_correct);
    end
    @(posedge clk); #1;
    s_res_valid = 1'b0;
    n_tests++;
    if (s_total !== 3'd7 || s_correct !== 3'd7 || s_upd_valid !== 1'b1 || s_mispredict !== 1'b1) begin
      n_fail++; $display("FAIL sat_mispredict: got %0d/%0d uv=%b mis=%b expected 7/7 1 1",
                         s_total, s_correct, s_upd_valid, s_mispredict);
    end
  endtask

  initial begin
    test_reset();
    test_correct();
    test_mispredict();
    test_full_and_back_to_back();
    test_flush_drops_push();
    test_empty_and_reset_mid();
    test_random();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
